branch_seq: RTL and testbench
=============================

Name: branch_seq

Overview:
- Parametrised successor of the CPU's branch/reset-vector unit. Sits between the decoder, the status register and the PC.
- Handles conditional and unconditional branches and the reset/NMI/IRQ vector fetch sequences, issuing PC-load and vector-fetch requests.
- Adds signed relative-offset arithmetic, page-cross penalty, interrupt priority and a generic address width.

Parameters:
- ADDR_W, 16, PC/address width (>=9).
- VEC_BASE, 16'hFFFA, NMI vector low-byte address; RST = VEC_BASE+2, IRQ = VEC_BASE+4 (modulo 2^ADDR_W).
- C_BIT, 7, carry position in status.
- Z_BIT, 6, zero position.
- I_BIT, 5, interrupt-disable position.
- V_BIT, 2, overflow position.
- N_BIT, 0, negative position.

Ports:
- clk_1  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = in reset).
- sync  in  1  decoder at instruction boundary; interrupts accepted only when high.
- branch_uncon  in  1  unconditional jump strobe.
- branch_con  in  1  conditional branch strobe; offset on data_bus.
- branch_op  in  3  condition select.
- status  in  8  processor status.
- data_bus  in  8  offset / vector byte.
- jmp_addr  in  ADDR_W  absolute jump target.
- pc  in  ADDR_W  address of the next instruction.
- nmi  in  1  non-maskable interrupt, rising-edge sensitive.
- irq  in  1  maskable interrupt, level sensitive.
- pc_target  out  ADDR_W  load value.
- pc_load  out  1  PC loads pc_target this cycle.
- pc_inc  out  1  PC increments normally.
- vec_fetch  out  1  memory read of vec_addr requested.
- vec_addr  out  ADDR_W  vector byte address.
- normal  out  1  sequencer in IDLE.
- taken  out  1  one-cycle pulse, conditional branch taken.
- page_penalty  out  1  page-fix cycle active.

Behaviour:
- All outputs registered.
- rst low (async): state RST_LO, all outputs 0, nmi_pending 0, captured bytes 0. A reset mid-sequence aborts it; nothing is queued.
- States: IDLE, RST_LO, RST_HI, VEC_LO, VEC_HI, BR_FIX, LOAD.
- Reset sequence:
  - RST_LO: vec_fetch=1, vec_addr=VEC_BASE+2; data_bus captured as lo on exit.
  - RST_HI: vec_addr=VEC_BASE+3; hi captured.
  - LOAD: pc_load=1, pc_target={hi,lo}, zero-extended to ADDR_W.
  - Then IDLE. Total 3 cycles from first edge after rst rises.
- IDLE: normal=1, pc_inc=1. Request priority, sampled each edge:
  1. nmi_pending with sync.
  2. irq && !status[I_BIT] with sync.
  3. branch_uncon.
  4. branch_con.
- Interrupt: VEC_LO → VEC_HI → LOAD, as reset but with base VEC_BASE (NMI) or VEC_BASE+4 (IRQ). nmi_pending clears on entry to VEC_LO.
- nmi edge detector runs in every state. An edge during any sequence stays pending. A second edge while pending is absorbed.
- branch_uncon: next cycle LOAD with pc_target=jmp_addr. branch_uncon wins over a simultaneous branch_con.
- branch_con conditions, by branch_op 0-7:
  - 0 ~C, 1 C, 2 Z, 3 N, 4 ~Z, 5 ~N, 6 ~V, 7 V.
- Not taken: stay IDLE, pc_inc stays 1, no pulse.
- Taken: target = pc + sign-extended data_bus, modulo 2^ADDR_W (wraps at 0 and at top). taken=1 for one cycle.
  - If target[ADDR_W-1:8] == pc[ADDR_W-1:8]: LOAD.
  - Else: BR_FIX (page_penalty=1, one cycle), then LOAD.
- Outside IDLE: pc_inc=0, normal=0. branch_uncon/branch_con/irq ignored, not queued.

Optional Feature:
- BRANCH_PAGE_PENALTY_EN defined: page-crossing taken branches insert BR_FIX as above.
- Undefined: BR_FIX removed; every taken branch goes directly to LOAD; page_penalty tied 0.

Test Plan:
- Release rst, data_bus 8'h34 in RST_LO, 8'h12 in RST_HI → vec_addr FFFC then FFFD; pc_load=1 with pc_target 16'h1234 on 3rd cycle; normal=1 on 4th.
- pc=16'h10F0, branch_op=2, Z=1, data_bus=8'h20 → taken pulse; with macro: BR_FIX cycle, then pc_target 16'h1110. Without macro: load next cycle.
- pc=16'h0005, branch_op=1, C=1, data_bus=8'hF0 → pc_target 16'hFFF5 (wrap). Same with C=0 → no load, pc_inc stays 1.
- nmi rising, irq high, I=0, sync=1 in same cycle → NMI vector fetched (FFFA/FFFB) first; IRQ sequence (FFFE/FFFF) follows on the next sync.
- irq high, I=1, sync=1 → no vector fetch. NMI pulse during IRQ sequence → NMI taken immediately after return to IDLE.
- Assert rst low during VEC_HI → all outputs 0 at once; after release, reset sequence restarts at FFFC; prior nmi_pending lost.

Source files
------------

// File: rtl/branch_seq.sv
// Branch / reset-vector sequencer: reset, NMI and IRQ vector fetches, absolute and relative branches.
// Optional BRANCH_PAGE_PENALTY_EN inserts a BR_FIX cycle on taken branches that cross a 256-byte page.
module branch_seq #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] VEC_BASE = ADDR_W'(16'hFFFA),
  parameter int                C_BIT    = 7,
  parameter int                Z_BIT    = 6,
  parameter int                I_BIT    = 5,
  parameter int                V_BIT    = 2,
  parameter int                N_BIT    = 0
) (
  input  logic              clk_1,
  input  logic              rst,
  input  logic              sync,
  input  logic              branch_uncon,
  input  logic              branch_con,
  input  logic [2:0]        branch_op,
  input  logic [7:0]        status,
  input  logic [7:0]        data_bus,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic [ADDR_W-1:0] pc,
  input  logic              nmi,
  input  logic              irq,
  output logic [ADDR_W-1:0] pc_target,
  output logic              pc_load,
  output logic              pc_inc,
  output logic              vec_fetch,
  output logic [ADDR_W-1:0] vec_addr,
  output logic              normal,
  output logic              taken,
  output logic              page_penalty
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST_LO, S_RST_HI, S_VEC_LO, S_VEC_HI, S_BR_FIX, S_LOAD
  } state_t;

  localparam logic [ADDR_W-1:0] NMI_V = VEC_BASE;
  localparam logic [ADDR_W-1:0] RST_V = VEC_BASE + ADDR_W'(2);
  localparam logic [ADDR_W-1:0] IRQ_V = VEC_BASE + ADDR_W'(4);

  state_t            state_q, state_d;
  logic              boot_q;
  logic              nmi_q, nmi_pend_q, nmi_pend_d;
  logic [7:0]        lo_q;
  logic [ADDR_W-1:0] tgt_q;

  logic [ADDR_W-1:0] pc_target_q, pc_target_d;
  logic [ADDR_W-1:0] vec_addr_q, vec_addr_d;
  logic              pc_load_q, pc_load_d;
  logic              pc_inc_q, pc_inc_d;
  logic              vec_fetch_q, vec_fetch_d;
  logic              normal_q, normal_d;
  logic              taken_q, taken_d;

  logic              nmi_edge, nmi_req, irq_req, cond_ok, br_cross, in_idle;
  logic              take_nmi, take_irq, take_jmp, take_br;
  logic [ADDR_W-1:0] br_tgt;
  logic              unused_status;

  assign unused_status = ^status;

  // A fresh edge counts in the same cycle so NMI beats a coincident IRQ.
  assign nmi_edge = nmi & ~nmi_q;
  assign nmi_req  = nmi_pend_q | nmi_edge;
  assign irq_req  = irq & ~status[I_BIT];

  always_comb begin
    cond_ok = 1'b0;
    case (branch_op)
      3'd0: cond_ok = ~status[C_BIT];
      3'd1: cond_ok =  status[C_BIT];
      3'd2: cond_ok =  status[Z_BIT];
      3'd3: cond_ok =  status[N_BIT];
      3'd4: cond_ok = ~status[Z_BIT];
      3'd5: cond_ok = ~status[N_BIT];
      3'd6: cond_ok = ~status[V_BIT];
      3'd7: cond_ok =  status[V_BIT];
      default: cond_ok = 1'b0;
    endcase
  end

  assign br_tgt   = pc + {{(ADDR_W-8){data_bus[7]}}, data_bus};
  assign br_cross = br_tgt[ADDR_W-1:8] != pc[ADDR_W-1:8];

  assign in_idle  = state_q == S_IDLE;
  assign take_nmi = in_idle & sync & nmi_req;
  assign take_irq = in_idle & sync & ~nmi_req & irq_req;
  assign take_jmp = in_idle & ~take_nmi & ~take_irq & branch_uncon;
  assign take_br  = in_idle & ~take_nmi & ~take_irq & ~branch_uncon & branch_con & cond_ok;

  always_comb begin
    nmi_pend_d = take_nmi ? 1'b0 : (nmi_pend_q | nmi_edge);
  end

  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) state_q <= S_RST_LO;
    else      state_q <= state_d;
  end

  // The reset cycle itself sits in RST_LO with outputs forced low; the fetch starts one edge later.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST_LO: state_d = boot_q ? S_RST_LO : S_RST_HI;
      S_RST_HI: state_d = S_LOAD;
      S_VEC_LO: state_d = S_VEC_HI;
      S_VEC_HI: state_d = S_LOAD;
      S_BR_FIX: state_d = S_LOAD;
      S_LOAD:   state_d = S_IDLE;
      S_IDLE: begin
        if (take_nmi || take_irq) state_d = S_VEC_LO;
        else if (take_jmp)        state_d = S_LOAD;
        else if (take_br) begin
`ifdef BRANCH_PAGE_PENALTY_EN
          state_d = br_cross ? S_BR_FIX : S_LOAD;
`else
          state_d = S_LOAD;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_target_d = '0;
    vec_addr_d  = '0;
    pc_load_d   = 1'b0;
    pc_inc_d    = 1'b0;
    vec_fetch_d = 1'b0;
    normal_d    = 1'b0;
    taken_d     = take_br;
    case (state_d)
      S_IDLE: begin
        normal_d = 1'b1;
        pc_inc_d = 1'b1;
      end
      S_RST_LO: begin
        vec_fetch_d = 1'b1;
        vec_addr_d  = RST_V;
      end
      S_VEC_LO: begin
        vec_fetch_d = 1'b1;
        vec_addr_d  = take_nmi ? NMI_V : IRQ_V;
      end
      S_RST_HI, S_VEC_HI: begin
        vec_fetch_d = 1'b1;
        vec_addr_d  = vec_addr_q + ADDR_W'(1);
      end
      S_LOAD: begin
        pc_load_d = 1'b1;
        case (state_q)
          S_RST_HI, S_VEC_HI: pc_target_d = ADDR_W'({data_bus, lo_q});
          S_BR_FIX:           pc_target_d = tgt_q;
          default:            pc_target_d = take_jmp ? jmp_addr : br_tgt;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      boot_q      <= 1'b1;
      nmi_q       <= 1'b0;
      nmi_pend_q  <= 1'b0;
      lo_q        <= '0;
      tgt_q       <= '0;
      pc_target_q <= '0;
      vec_addr_q  <= '0;
      pc_load_q   <= 1'b0;
      pc_inc_q    <= 1'b0;
      vec_fetch_q <= 1'b0;
      normal_q    <= 1'b0;
      taken_q     <= 1'b0;
    end else begin
      boot_q      <= 1'b0;
      nmi_q       <= nmi;
      nmi_pend_q  <= nmi_pend_d;
      if ((state_q == S_RST_LO && !boot_q) || state_q == S_VEC_LO) lo_q <= data_bus;
      if (take_br) tgt_q <= br_tgt;
      pc_target_q <= pc_target_d;
      vec_addr_q  <= vec_addr_d;
      pc_load_q   <= pc_load_d;
      pc_inc_q    <= pc_inc_d;
      vec_fetch_q <= vec_fetch_d;
      normal_q    <= normal_d;
      taken_q     <= taken_d;
    end
  end

`ifdef BRANCH_PAGE_PENALTY_EN
  logic page_penalty_q;
  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) page_penalty_q <= 1'b0;
    else      page_penalty_q <= (state_d == S_BR_FIX);
  end
  assign page_penalty = page_penalty_q;
`else
  logic unused_cross;
  assign unused_cross = br_cross;
  assign page_penalty = 1'b0;
`endif

  assign pc_target = pc_target_q;
  assign pc_load   = pc_load_q;
  assign pc_inc    = pc_inc_q;
  assign vec_fetch = vec_fetch_q;
  assign vec_addr  = vec_addr_q;
  assign normal    = normal_q;
  assign taken     = taken_q;

endmodule

// File: tb/tb_branch_seq.sv
// Directed bench for branch_seq: reset fetch, relative/absolute branches, NMI/IRQ priority, mid-sequence reset.
module tb_branch_seq;

  logic        clk_1 = 1'b0;
  logic        rst = 1'b0;
  logic        sync = 1'b0, branch_uncon = 1'b0, branch_con = 1'b0;
  logic [2:0]  branch_op = '0;
  logic [7:0]  status = '0, data_bus = '0;
  logic [15:0] jmp_addr = '0, pc = '0;
  logic        nmi = 1'b0, irq = 1'b0;
  logic [15:0] pc_target, vec_addr;
  logic        pc_load, pc_inc, vec_fetch, normal, taken, page_penalty;

  int checks = 0;
  int errors = 0;

  branch_seq dut (
    .clk_1(clk_1), .rst(rst), .sync(sync), .branch_uncon(branch_uncon),
    .branch_con(branch_con), .branch_op(branch_op), .status(status),
    .data_bus(data_bus), .jmp_addr(jmp_addr), .pc(pc), .nmi(nmi), .irq(irq),
    .pc_target(pc_target), .pc_load(pc_load), .pc_inc(pc_inc),
    .vec_fetch(vec_fetch), .vec_addr(vec_addr), .normal(normal),
    .taken(taken), .page_penalty(page_penalty)
  );

  always #5 clk_1 = ~clk_1;

  task automatic step();
    @(posedge clk_1); #1;
  endtask

  task automatic test_reset();
    step(); step();
    checks++; if ({pc_load, pc_inc, vec_fetch, normal, taken, page_penalty} !== 6'b0) begin errors++; $display("FAIL reset_flags got %b exp 000000", {pc_load, pc_inc, vec_fetch, normal, taken, page_penalty}); end
    checks++; if (vec_addr !== 16'h0000 || pc_target !== 16'h0000) begin errors++; $display("FAIL reset_buses got %h/%h exp 0000/0000", vec_addr, pc_target); end
    rst = 1'b1; data_bus = 8'h00;
    step();
    checks++; if (vec_fetch !== 1'b1 || vec_addr !== 16'hFFFC || normal !== 1'b0) begin errors++; $display("FAIL rst_lo got f=%b a=%h n=%b exp 1 FFFC 0", vec_fetch, vec_addr, normal); end
    data_bus = 8'h34;
    step();
    checks++; if (vec_fetch !== 1'b1 || vec_addr !== 16'hFFFD) begin errors++; $display("FAIL rst_hi got f=%b a=%h exp 1 FFFD", vec_fetch, vec_addr); end
    data_bus = 8'h12;
    step();
    checks++; if (pc_load !== 1'b1 || pc_target !== 16'h1234 || vec_fetch !== 1'b0) begin errors++; $display("FAIL rst_load got l=%b t=%h f=%b exp 1 1234 0", pc_load, pc_target, vec_fetch); end
    step();
    checks++; if (normal !== 1'b1 || pc_inc !== 1'b1 || pc_load !== 1'b0) begin errors++; $display("FAIL rst_idle got n=%b i=%b l=%b exp 1 1 0", normal, pc_inc, pc_load); end
  endtask

  task automatic test_branch_cross();
    pc = 16'h10F0; status = 8'h40; branch_op = 3'd2; data_bus = 8'h20; branch_con = 1'b1;
    step();
    branch_con = 1'b0;
`ifdef BRANCH_PAGE_PENALTY_EN
    checks++; if (page_penalty !== 1'b1 || taken !== 1'b1 || pc_load !== 1'b0) begin errors++; $display("FAIL cross_fix got p=%b t=%b l=%b exp 1 1 0", page_penalty, taken, pc_load); end
    step();
    checks++; if (pc_load !== 1'b1 || pc_target !== 16'h1110 || taken !== 1'b0 || page_penalty !== 1'b0) begin errors++; $display("FAIL cross_load got l=%b t=%h tk=%b p=%b exp 1 1110 0 0", pc_load, pc_target, taken, page_penalty); end
`else
    checks++; if (pc_load !== 1'b1 || pc_target !== 16'h1110 || taken !== 1'b1 || page_penalty !== 1'b0) begin errors++; $display("FAIL cross_load got l=%b t=%h tk=%b p=%b exp 1 1110 1 0", pc_load, pc_target, taken, page_penalty); end
`endif
    step();
    checks++; if (normal !== 1'b1 || taken !== 1'b0) begin errors++; $display("FAIL cross_idle got n=%b tk=%b exp 1 0", normal, taken); end
  endtask

  task automatic test_branch_same_page();
    pc = 16'h1000; status = 8'h00; branch_op = 3'd4; data_bus = 8'h10; branch_con = 1'b1;
    step();
    branch_con = 1'b0;
    checks++; if (pc_load !== 1'b1 || pc_target !== 16'h1010 || taken !== 1'b1 || page_penalty !== 1'b0) begin errors++; $display("FAIL same_page got l=%b t=%h tk=%b p=%b exp 1 1010 1 0", pc_load, pc_target, taken, page_penalty); end
    step();
  endtask

  task automatic test_branch_wrap();
    pc = 16'h0005; status = 8'h80; branch_op = 3'd1; data_bus = 8'hF0; branch_con = 1'b1;
    step();
    branch_con = 1'b0;
`ifdef BRANCH_PAGE_PENALTY_EN
    checks++; if (page_penalty !== 1'b1 || taken !== 1'b1) begin errors++; $display("FAIL wrap_fix got p=%b tk=%b exp 1 1", page_penalty, taken); end
    step();
`endif
    checks++; if (pc_load !== 1'b1 || pc_target !== 16'hFFF5) begin errors++; $display("FAIL wrap_load got l=%b t=%h exp 1 FFF5", pc_load, pc_target); end
    step();
    status = 8'h00; branch_con = 1'b1;
    step();
    branch_con = 1'b0;
    checks++; if (normal !== 1'b1 || pc_inc !== 1'b1 || pc_load !== 1'b0 || taken !== 1'b0) begin errors++; $display("FAIL not_taken got n=%b i=%b l=%b tk=%b exp 1 1 0 0", normal, pc_inc, pc_load, taken); end
  endtask

  task automatic test_uncon();
    jmp_addr = 16'hABCD; status = 8'h00; branch_op = 3'd0; data_bus = 8'h05;
    branch_uncon = 1'b1; branch_con = 1'b1;
    step();
    branch_uncon = 1'b0; branch_con = 1'b0;
    checks++; if (pc_load !== 1'b1 || pc_target !== 16'hABCD || taken !== 1'b0) begin errors++; $display("FAIL uncon got l=%b t=%h tk=%b exp 1 ABCD 0", pc_load, pc_target, taken); end
    step();
    checks++; if (normal !== 1'b1) begin errors++; $display("FAIL uncon_idle got %b exp 1", normal); end
  endtask

  task automatic test_nmi_irq();
    status = 8'h00; irq = 1'b1; sync = 1'b1; nmi = 1'b1;
    step();
    checks++; if (vec_fetch !== 1'b1 || vec_addr !== 16'hFFFA) begin errors++; $display("FAIL nmi_lo got f=%b a=%h exp 1 FFFA", vec_fetch, vec_addr); end
    nmi = 1'b0; data_bus = 8'h78;
    step();
    checks++; if (vec_addr !== 16'hFFFB) begin errors++; $display("FAIL nmi_hi got %h exp FFFB", vec_addr); end
    data_bus = 8'h56;
    step();
    checks++; if (pc_load !== 1'b1 || pc_target !== 16'h5678) begin errors++; $display("FAIL nmi_load got l=%b t=%h exp 1 5678", pc_load, pc_target); end
    step();
    checks++; if (normal !== 1'b1) begin errors++; $display("FAIL nmi_idle got %b exp 1", normal); end
    step();
    checks++; if (vec_fetch !== 1'b1 || vec_addr !== 16'hFFFE) begin errors++; $display("FAIL irq_lo got f=%b a=%h exp 1 FFFE", vec_fetch, vec_addr); end
    irq = 1'b0; nmi = 1'b1; data_bus = 8'hAA;
    step();
    checks++; if (vec_addr !== 16'hFFFF) begin errors++; $display("FAIL irq_hi got %h exp FFFF", vec_addr); end
    nmi = 1'b0; data_bus = 8'hBB;
    step();
    checks++; if (pc_load !== 1'b1 || pc_target !== 16'hBBAA) begin errors++; $display("FAIL irq_load got l=%b t=%h exp 1 BBAA", pc_load, pc_target); end
    step();
    checks++; if (normal !== 1'b1) begin errors++; $display("FAIL irq_idle got %b exp 1", normal); end
    step();
    checks++; if (vec_fetch !== 1'b1 || vec_addr !== 16'hFFFA) begin errors++; $display("FAIL nmi_held got f=%b a=%h exp 1 FFFA", vec_fetch, vec_addr); end
    step(); step(); step(); step();
    checks++; if (normal !== 1'b1 || vec_fetch !== 1'b0) begin errors++; $display("FAIL nmi_cleared got n=%b f=%b exp 1 0", normal, vec_fetch); end
  endtask

  task automatic test_irq_masked();
    status = 8'h20; irq = 1'b1; sync = 1'b1;
    step(); step();
    checks++; if (vec_fetch !== 1'b0 || normal !== 1'b1) begin errors++; $display("FAIL irq_masked got f=%b n=%b exp 0 1", vec_fetch, normal); end
    status = 8'h00; sync = 1'b0;
    step();
    checks++; if (vec_fetch !== 1'b0 || normal !== 1'b1) begin errors++; $display("FAIL irq_nosync got f=%b n=%b exp 0 1", vec_fetch, normal); end
    irq = 1'b0; sync = 1'b1;
  endtask

  task automatic test_reset_mid();
    status = 8'h00; irq = 1'b1; sync = 1'b1;
    step();
    irq = 1'b0; nmi = 1'b1;
    step();
    checks++; if (vec_addr !== 16'hFFFF || vec_fetch !== 1'b1) begin errors++; $display("FAIL mid_hi got a=%h f=%b exp FFFF 1", vec_addr, vec_fetch); end
    rst = 1'b0; #1;
    checks++; if ({pc_load, pc_inc, vec_fetch, normal, taken, page_penalty} !== 6'b0 || vec_addr !== 16'h0000 || pc_target !== 16'h0000) begin errors++; $display("FAIL mid_async got %b %h %h exp 000000 0000 0000", {pc_load, pc_inc, vec_fetch, normal, taken, page_penalty}, vec_addr, pc_target); end
    nmi = 1'b0;
    step(); step();
    rst = 1'b1; data_bus = 8'h00;
    step();
    checks++; if (vec_fetch !== 1'b1 || vec_addr !== 16'hFFFC) begin errors++; $display("FAIL mid_restart got f=%b a=%h exp 1 FFFC", vec_fetch, vec_addr); end
    data_bus = 8'hCD;
    step();
    data_bus = 8'hEF;
    step();
    checks++; if (pc_load !== 1'b1 || pc_target !== 16'hEFCD) begin errors++; $display("FAIL mid_load got l=%b t=%h exp 1 EFCD", pc_load, pc_target); end
    step(); step();
    checks++; if (normal !== 1'b1 || vec_fetch !== 1'b0) begin errors++; $display("FAIL mid_nmi_lost got n=%b f=%b exp 1 0", normal, vec_fetch); end
  endtask

  initial begin
    test_reset();
    test_branch_cross();
    test_branch_same_page();
    test_branch_wrap();
    test_uncon();
    test_nmi_irq();
    test_irq_masked();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
